// File: rtl/gs_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gs_stream_pkg
//  Description : Shared definitions for the GS raw-signal host stream path:
//                FSM state encoding, default widths and the byte-swap helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package gs_stream_pkg;

    localparam int GS_DATA_W = 16;
    localparam int GS_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } gs_state_e;

    // Host expects the opposite byte order of the producer's 16-bit samples.
    function automatic logic [GS_DATA_W-1:0] gs_swap_bytes(input logic [GS_DATA_W-1:0] d);
        return {d[7:0], d[15:8]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gs_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : gs_sync_fifo
//  Description : Single-clock FIFO, 2**ADDR_W words, registered read data.
//                Ports: clk/rst (async active-high), i_flush (sync clear),
//                i_wr_en/i_din write side, i_rd_en/o_dout read side,
//                o_full, o_empty (registered), o_count (occupancy).
//  Revision    : 1.0 - initial release
// ============================================================================
module gs_sync_fifo #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(1) << ADDR_W;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic [DATA_W-1:0] dout_q,   dout_d;
    logic              empty_q,  empty_d;

    logic w_wr;
    logic w_rd;

    // A write at full is refused even if a read frees a slot this cycle.
    assign w_wr = i_wr_en & ~o_full & ~i_flush;
    assign w_rd = i_rd_en & ~empty_q & ~i_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_wr) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_rd) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                dout_d   = mem[rd_ptr_q];
            end
            count_d = count_q + {{ADDR_W{1'b0}}, w_wr} - {{ADDR_W{1'b0}}, w_rd};
        end
        // Empty flag tracks the post-update occupancy so it is glitch-free.
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem[wr_ptr_q] <= i_din;
        end
    end

    assign o_dout  = dout_q;
    assign o_full  = (count_q == c_depth);
    assign o_empty = empty_q;
    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/gs_host_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : gs_host_stream_tx
//  Description : FPGA-to-host transmitter for the GS raw-signal path. Buffers
//                producer samples and presents them on the Xillybus read port,
//                raising EOF once a programmed-length frame has been read.
//                Ports: iClk/iReset; iFrameStart/iFrameLen frame arm;
//                iWrEn/iData/oFull/oOverflow producer side; oBusy status;
//                iRden/oEmpty/oData/oEof/iOpen Xillybus read side.
//  Revision    : 1.0 - initial release
// ============================================================================
module gs_host_stream_tx
    import gs_stream_pkg::*;
#(
    parameter int DATA_W     = GS_DATA_W,
    parameter int ADDR_W     = GS_ADDR_W,
    parameter bit SWAP_BYTES = 1'b1
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iFrameStart,
    input  logic [ADDR_W:0]   iFrameLen,
    input  logic              iWrEn,
    input  logic [DATA_W-1:0] iData,
    output logic              oFull,
    output logic              oBusy,
    output logic              oOverflow,
    input  logic              iRden,
    output logic              oEmpty,
    output logic [DATA_W-1:0] oData,
    output logic              oEof,
    input  logic              iOpen
);

    gs_state_e       state_q,     state_d;
    logic [ADDR_W:0] frame_len_q, frame_len_d;
    logic [ADDR_W:0] wr_cnt_q,    wr_cnt_d;
    logic [ADDR_W:0] rd_cnt_q,    rd_cnt_d;
    logic            overflow_q,  overflow_d;
    logic            eof_q,       eof_d;

    logic              w_flush;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [ADDR_W:0]   w_fifo_count;
    logic [ADDR_W:0]   w_occ_next;
    logic [DATA_W-1:0] w_fifo_dout;

    gs_sync_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (iClk),
        .rst     (iReset),
        .i_flush (w_flush),
        .i_wr_en (w_wr_acc),
        .i_din   (iData),
        .i_rd_en (w_rd_acc),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_occ_next = w_fifo_count + {{ADDR_W{1'b0}}, w_wr_acc} - {{ADDR_W{1'b0}}, w_rd_acc};

    always_comb begin
        state_d     = state_q;
        frame_len_d = frame_len_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        overflow_d  = overflow_q;
        w_flush     = 1'b0;
        w_wr_acc    = 1'b0;
        w_rd_acc    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iFrameStart && iOpen) begin
                    frame_len_d = iFrameLen;
                    wr_cnt_d    = '0;
                    rd_cnt_d    = '0;
                    overflow_d  = 1'b0;
                    // An empty frame is complete as soon as it is armed.
                    state_d     = (iFrameLen == '0) ? ST_DONE : ST_STREAM;
                end else if (iWrEn) begin
                    overflow_d = 1'b1;
                end
            end
            ST_STREAM: begin
                if (!iOpen) begin
                    // Host closed mid-frame: discard everything buffered.
                    w_flush  = 1'b1;
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
                    state_d  = ST_IDLE;
                    if (iWrEn) begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    w_wr_acc = iWrEn & ~w_fifo_full & (wr_cnt_q < frame_len_q);
                    w_rd_acc = iRden & ~w_fifo_empty;
                    if (iWrEn && !w_wr_acc) begin
                        overflow_d = 1'b1;
                    end
                    wr_cnt_d = wr_cnt_q + {{ADDR_W{1'b0}}, w_wr_acc};
                    rd_cnt_d = rd_cnt_q + {{ADDR_W{1'b0}}, w_rd_acc};
                    // Look ahead so EOF and the final empty appear together.
                    if ((rd_cnt_d == frame_len_q) && (w_occ_next == '0)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (iWrEn) begin
                    overflow_d = 1'b1;
                end
                if (!iOpen) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        eof_d = (state_d == ST_DONE);
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q     <= ST_IDLE;
            frame_len_q <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            overflow_q  <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_len_q <= frame_len_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            overflow_q  <= overflow_d;
            eof_q       <= eof_d;
        end
    end

    generate
        if (SWAP_BYTES && (DATA_W == 16)) begin : g_swap
            assign oData = gs_swap_bytes(w_fifo_dout);
        end else begin : g_pass
            assign oData = w_fifo_dout;
        end
    endgenerate

    assign oFull     = w_fifo_full | ((state_q == ST_STREAM) && (wr_cnt_q == frame_len_q));
    assign oBusy     = (state_q != ST_IDLE);
    assign oOverflow = overflow_q;
    assign oEmpty    = w_fifo_empty;
    assign oEof      = eof_q;

endmodule
`default_nettype wire
